mprj_seq_monitor: RTL and testbench

//  Hardware checkpoint-sequence monitor for the user project. Watches a GPIO checkpoint
//  bus (e.g. mprj_io[31:16]) for a programmed ordered list of values, with a per-step timeout.

---
 rtl/seq_mon_pkg.sv | 15 +
 rtl/seq_mon_sync.sv | 29 ++
 rtl/mprj_seq_monitor.sv | 162 ++++++++++++++++
 tb/tb_mprj_seq_monitor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mon_pkg.sv
// Shared types and default sizes for the checkpoint-sequence monitor.
package seq_mon_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int TMO_W_DEF  = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/seq_mon_sync.sv
// Multi-bit 2-flop synchroniser for the checkpoint bus.
// Latency 2 cycles, no backpressure; output cleared by synchronous reset.
module seq_mon_sync
  import seq_mon_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mprj_seq_monitor.sv
// Checkpoint-sequence monitor: matches synchronised mon_data against a programmed list with per-step timeout.
// Match-to-status latency 1 cycle after sync; no backpressure. SEQ_MON_STRICT_EN adds unexpected-value failure.
module mprj_seq_monitor
  import seq_mon_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TMO_W  = TMO_W_DEF,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [IDX_W:0]    cfg_len,
  input  logic [TMO_W-1:0]  cfg_tmo,
  input  logic              start,
  input  logic [DATA_W-1:0] mon_data,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              tmo_flag,
  output logic [IDX_W:0]    step_idx,
  output logic [DATA_W-1:0] last_val
);

  localparam logic [IDX_W:0]   LEN_MAX  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   STEP_ONE = (IDX_W+1)'(1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] exp_mem_q [DEPTH];
  logic [DATA_W-1:0] exp_cur;

  state_e            state_q, state_d;
  logic [IDX_W:0]    step_q, step_d, step_inc;
  logic [IDX_W:0]    len_q, len_d, len_clamp;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              tflag_q, tflag_d;
  logic              match, at_end, tmo_hit, bad_chg;

  seq_mon_sync #(.DATA_W(DATA_W)) u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (mon_data),
    .q_o   (s)
  );

  // Expected list is deliberately not reset; it is only writable outside RUN.
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && state_q != ST_RUN) exp_mem_q[cfg_addr] <= cfg_wdata;
  end

  assign exp_cur   = exp_mem_q[step_q[IDX_W-1:0]];
  assign step_inc  = step_q + STEP_ONE;
  assign match     = (s == exp_cur);
  assign at_end    = (step_q == len_q);
  assign tmo_hit   = (tmo_q != '0) && (cnt_q == tmo_q - TMO_ONE);
  assign len_clamp = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

`ifdef SEQ_MON_STRICT_EN
  logic [DATA_W-1:0] prev_s_q;
  logic [DATA_W-1:0] last_match_q;

  // "Last matched" starts as the bus value seen when the run is launched.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_s_q     <= '0;
      last_match_q <= '0;
    end else begin
      prev_s_q <= s;
      if (state_q != ST_RUN && start)               last_match_q <= s;
      else if (state_q == ST_RUN && !at_end && match) last_match_q <= s;
    end
  end

  assign bad_chg = (s != prev_s_q) && (s != last_match_q);
`else
  assign bad_chg = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tflag_d = tflag_q;
    case (state_q)
      ST_RUN: begin
        if (at_end) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
        end else if (match) begin
          step_d = step_inc;
          cnt_d  = '0;
          if (step_inc == len_q) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end
        end else if (bad_chg) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          tflag_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_ONE;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_RUN;
          step_d  = '0;
          cnt_d   = '0;
          len_d   = len_clamp;
          tmo_d   = cfg_tmo;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tflag_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tflag_q <= tflag_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign tmo_flag = tflag_q;
  assign step_idx = step_q;
  assign last_val = s;

endmodule

// File: tb/tb_mprj_seq_monitor.sv
// Randomised and directed bench for mprj_seq_monitor against a step-list reference model.
module tb_mprj_seq_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [3:0]  cfg_len;
  logic [23:0] cfg_tmo;
  logic        start;
  logic [15:0] mon_data;
  logic        busy, pass, fail, tmo_flag;
  logic [3:0]  step_idx;
  logic [15:0] last_val;

  int errs = 0;
  int checks = 0;

`ifdef SEQ_MON_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic [15:0] exp_q [8];
  logic [15:0] plan [$];
  bit          ebusy [];
  int          estep [];
  int          m_res;
  bit          m_tflag;
  int          m_step;

  always #5 clk = ~clk;

  mprj_seq_monitor dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_len  (cfg_len),
    .cfg_tmo  (cfg_tmo),
    .start    (start),
    .mon_data (mon_data),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail),
    .tmo_flag (tmo_flag),
    .step_idx (step_idx),
    .last_val (last_val)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mon_at(int x);
    if (x < 0) return plan[0];
    if (x >= plan.size()) return plan[plan.size()-1];
    return plan[x];
  endfunction

  task automatic push(logic [15:0] v, int n);
    for (int k = 0; k < n; k++) plan.push_back(v);
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Walks the bus trace as the synchronised value sees it (2 cycles late) and applies the step rules.
  task automatic model(int len, int tmo, int ncyc);
    int L, idx, idle;
    logic [15:0] sv, prev, lastm;
    bit run;
    L = (len > 8) ? 8 : len;
    idx = 0; idle = 0; run = 1'b1;
    m_res = 0; m_tflag = 1'b0;
    ebusy = new[ncyc+1];
    estep = new[ncyc+1];
    ebusy[0] = 1'b0; estep[0] = 0;
    ebusy[1] = 1'b1; estep[1] = 0;
    prev = mon_at(-2);
    lastm = prev;
    for (int c = 1; c < ncyc; c++) begin
      if (run) begin
        sv = mon_at(c - 2);
        if (idx == L) begin
          run = 1'b0; m_res = 1;
        end else if (sv == exp_q[idx]) begin
          idx++; idle = 0; lastm = sv;
          if (idx == L) begin run = 1'b0; m_res = 1; end
        end else if (STRICT && sv != prev && sv != lastm) begin
          run = 1'b0; m_res = 2;
        end else if (tmo != 0) begin
          idle++;
          if (idle == tmo) begin run = 1'b0; m_res = 2; m_tflag = 1'b1; end
        end
        prev = sv;
      end
      ebusy[c+1] = run;
      estep[c+1] = idx;
    end
    m_step = idx;
  endtask

  task automatic run_plan(string name, int len, int tmo, int ncyc);
    int bad_b, bad_s;
    if (busy) do_reset;
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_wdata = exp_q[i];
      tick;
    end
    cfg_we = 1'b0;
    mon_data = plan[0];
    tick; tick; tick;
    model(len, tmo, ncyc);
    bad_b = -1; bad_s = -1;
    for (int c = 0; c <= ncyc; c++) begin
      if (c >= 1) begin
        if (bad_b < 0 && busy !== ebusy[c]) bad_b = c;
        if (bad_s < 0 && step_idx !== 4'(estep[c])) bad_s = c;
      end
      if (c == ncyc) break;
      start     = (c == 0) || (ebusy[c] && $urandom_range(0, 5) == 0);
      cfg_len   = (c == 0) ? 4'(len) : 4'($urandom);
      cfg_tmo   = (c == 0) ? 24'(tmo) : 24'($urandom);
      cfg_we    = (c > 0) && ebusy[c] && ($urandom_range(0, 3) == 0);
      cfg_addr  = 3'($urandom);
      cfg_wdata = 16'($urandom);
      mon_data  = mon_at(c);
      tick;
    end
    start = 1'b0; cfg_we = 1'b0;
    checks++;
    if (bad_b >= 0) begin
      errs++; $display("FAIL %s busy_trace cycle %0d got %0b exp %0b", name, bad_b, !ebusy[bad_b], ebusy[bad_b]);
    end
    checks++;
    if (bad_s >= 0) begin
      errs++; $display("FAIL %s step_trace first bad cycle %0d exp %0d", name, bad_s, estep[bad_s]);
    end
    checks++;
    if (pass !== (m_res == 1)) begin errs++; $display("FAIL %s pass got %0b exp %0b", name, pass, m_res == 1); end
    checks++;
    if (fail !== (m_res == 2)) begin errs++; $display("FAIL %s fail got %0b exp %0b", name, fail, m_res == 2); end
    checks++;
    if (tmo_flag !== m_tflag) begin errs++; $display("FAIL %s tmo_flag got %0b exp %0b", name, tmo_flag, m_tflag); end
    checks++;
    if (step_idx !== 4'(m_step)) begin errs++; $display("FAIL %s step_idx got %0d exp %0d", name, step_idx, m_step); end
    checks++;
    if (last_val !== mon_at(ncyc - 2)) begin
      errs++; $display("FAIL %s last_val got %h exp %h", name, last_val, mon_at(ncyc - 2));
    end
  endtask

  task automatic check_all_zero(string name);
    checks++;
    if ({busy, pass, fail, tmo_flag} !== 4'b0) begin
      errs++; $display("FAIL %s flags got %b exp 0000", name, {busy, pass, fail, tmo_flag});
    end
    checks++;
    if (step_idx !== 4'd0) begin errs++; $display("FAIL %s step_idx got %0d exp 0", name, step_idx); end
    checks++;
    if (last_val !== 16'h0) begin errs++; $display("FAIL %s last_val got %h exp 0000", name, last_val); end
  endtask

  task automatic load_basic;
    exp_q[0] = 16'h003E; exp_q[1] = 16'h0044; exp_q[2] = 16'h004A; exp_q[3] = 16'h0050;
    for (int i = 4; i < 8; i++) exp_q[i] = 16'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1; mon_data = 16'hBEEF; start = 1'b1; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; cfg_len = 4'd4; cfg_tmo = 24'd10;
    tick; tick; tick;
    check_all_zero("reset");
    rst = 1'b0; start = 1'b0;
    tick;
  endtask

  task automatic test_in_order;
    load_basic;
    plan.delete();
    push(16'h0000, 3); push(16'h003E, 3); push(16'h0044, 3); push(16'h004A, 3); push(16'h0050, 3);
    run_plan("in_order", 4, 1000, plan.size() + 6);
    checks++;
    if (pass !== 1'b1 || step_idx !== 4'd4) begin
      errs++; $display("FAIL in_order_const pass=%0b step=%0d exp pass=1 step=4", pass, step_idx);
    end
  endtask

  task automatic test_timeout;
    load_basic;
    plan.delete();
    push(16'h0000, 3); push(16'h003E, 3); push(16'h0044, 3); push(16'h0000, 1010);
    run_plan("timeout", 4, 1000, plan.size() + 4);
    checks++;
    if ({fail, tmo_flag, busy} !== 3'b110 || step_idx !== 4'd2) begin
      errs++; $display("FAIL timeout_const fail/tmo/busy=%b step=%0d exp 110 step=2", {fail, tmo_flag, busy}, step_idx);
    end
  endtask

  task automatic test_noise;
    load_basic;
    plan.delete();
    push(16'h0000, 3); push(16'h003E, 3); push(16'h1234, 3);
    push(16'h0044, 3); push(16'h004A, 3); push(16'h0050, 3);
    run_plan("noise", 4, 1000, plan.size() + 6);
    checks++;
    if (STRICT ? (fail !== 1'b1 || tmo_flag !== 1'b0 || step_idx !== 4'd1) : (pass !== 1'b1)) begin
      errs++; $display("FAIL noise_const pass=%0b fail=%0b tmo=%0b step=%0d", pass, fail, tmo_flag, step_idx);
    end
  endtask

  task automatic test_len0_and_busy_ignore;
    plan.delete();
    push(16'h0101, 4);
    run_plan("len0", 0, 5, 6);
    for (int i = 0; i < 8; i++) exp_q[i] = 16'h0011 * 16'(i + 1);
    plan.delete();
    push(16'h0000, 40); push(16'h0011, 2); push(16'h0022, 2); push(16'h0033, 2);
    run_plan("busy_ignore", 3, 0, plan.size() + 5);
  endtask

  task automatic test_mid_reset;
    bit seen;
    load_basic;
    if (busy) do_reset;
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_wdata = exp_q[i];
      tick;
    end
    cfg_we = 1'b0;
    mon_data = 16'h0000;
    tick; tick; tick;
    start = 1'b1; cfg_len = 4'd4; cfg_tmo = 24'd1000;
    tick;
    start = 1'b0;
    mon_data = 16'h003E; tick; tick; tick;
    mon_data = 16'h0044;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (step_idx == 4'd2) seen = 1'b1;
      else tick;
    end
    checks++;
    if (!seen) begin errs++; $display("FAIL mid_reset_reach_step2 got %0d exp 2", step_idx); end
    rst = 1'b1;
    tick;
    check_all_zero("mid_reset");
    rst = 1'b0;
    plan.delete();
    push(16'h0000, 3); push(16'h003E, 2); push(16'h0044, 2); push(16'h004A, 2); push(16'h0050, 2);
    run_plan("after_reset", 4, 1000, plan.size() + 6);
  endtask

  task automatic test_no_timeout_dup;
    exp_q[0] = 16'hAB40; exp_q[1] = 16'hAB40;
    for (int i = 2; i < 8; i++) exp_q[i] = 16'($urandom);
    plan.delete();
    push(16'h0000, 10000); push(16'hAB40, 2); push(16'h0000, 4);
    run_plan("no_tmo_dup", 2, 0, plan.size() + 4);
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      errs++; $display("FAIL no_tmo_dup_const pass=%0b fail=%0b exp pass=1 fail=0", pass, fail);
    end
  endtask

  task automatic test_random;
    int len, tmo, lc, n;
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(0, 10);
      tmo = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 12);
      for (int i = 0; i < 8; i++)
        exp_q[i] = (i > 0 && $urandom_range(0, 3) == 0) ? exp_q[i-1] : 16'($urandom);
      plan.delete();
      push(16'($urandom), 1);
      lc = (len > 8) ? 8 : len;
      for (int i = 0; i < lc; i++) begin
        n = $urandom_range(0, (tmo != 0) ? tmo + 1 : 5);
        for (int k = 0; k < n; k++)
          plan.push_back($urandom_range(0, 1) ? plan[plan.size()-1] : 16'($urandom));
        push(exp_q[i], $urandom_range(1, 3));
      end
      run_plan($sformatf("random%0d", it), len, tmo, plan.size() + 5);
    end
  endtask

  initial begin
    test_reset;
    test_in_order;
    test_timeout;
    test_noise;
    test_len0_and_busy_ignore;
    test_mid_reset;
    test_no_timeout_dup;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
